// File: rtl/lamp_fpu_sqrt_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lamp_fpu_sqrt_issue                                                        |
// | Issue controller for lampFPU_sqrt: unpacks and classifies one LAMP float   |
// | operand, starts the sqrt unit, and returns the repacked result.            |
// | Optional watchdog: define LAMP_SQRT_ISSUE_TIMEOUT_EN                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lamp_fpu_sqrt_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [15:0] op_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic        busy_o,
  output logic        doSqrt_o,
  output logic        signum_op_o,
  output logic [7:0]  extExp_op_o,
  output logic [7:0]  extMant_op_o,
  output logic        isZero_op_o,
  output logic        isInf_op_o,
  output logic        isSNAN_op_o,
  output logic        isQNAN_op_o,
  input  logic        sqrt_valid_i,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [6:0]  f_res_i
`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);

  localparam logic [15:0] c_qnan = 16'h7FC0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_capture;
  logic        w_expire;
  logic        w_wait_expired;

  logic        r_sig;
  logic [7:0]  r_exp;
  logic [7:0]  r_mant;
  logic        r_zero;
  logic        r_inf;
  logic        r_snan;
  logic        r_qnan;
  logic [15:0] r_res;

  logic [7:0]  w_e;
  logic [6:0]  w_f;
  logic        w_e_zero;
  logic        w_e_max;
  logic        w_f_nz;

  // Denormals flush to zero, so the hidden bit and fraction both vanish.
  assign w_e      = op_i[14:7];
  assign w_f      = op_i[6:0];
  assign w_e_zero = (w_e == 8'h00);
  assign w_e_max  = (w_e == 8'hFF);
  assign w_f_nz   = (w_f != 7'h00);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid_i && op_ready_o) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (sqrt_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_wait_expired) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= 1'b0;
      r_exp   <= 8'h00;
      r_mant  <= 8'h00;
      r_zero  <= 1'b0;
      r_inf   <= 1'b0;
      r_snan  <= 1'b0;
      r_qnan  <= 1'b0;
      r_res   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sig  <= op_i[15];
        r_exp  <= w_e;
        r_mant <= w_e_zero ? 8'h00 : {1'b1, w_f};
        r_zero <= w_e_zero;
        r_inf  <= w_e_max & ~w_f_nz;
        r_snan <= w_e_max & w_f_nz & ~w_f[6];
        r_qnan <= w_e_max & w_f_nz & w_f[6];
      end
      if (w_capture) begin
        r_res <= {s_res_i, e_res_i, f_res_i};
      end else if (w_expire) begin
        r_res <= c_qnan;
      end
    end
  end

`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_timeout;

  // The counter holds the number of WAIT cycles already elapsed.
  assign w_wait_expired = (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
  assign timeout_o      = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end else if (r_state == S_RESP && res_ready_i) begin
        r_timeout <= 1'b0;
      end
    end
  end
`else
  assign w_wait_expired = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign op_ready_o   = (r_state == S_IDLE) && !rst;
  assign busy_o       = (r_state != S_IDLE);
  assign doSqrt_o     = (r_state == S_ISSUE);
  assign res_valid_o  = (r_state == S_RESP);
  assign res_o        = r_res;
  assign signum_op_o  = r_sig;
  assign extExp_op_o  = r_exp;
  assign extMant_op_o = r_mant;
  assign isZero_op_o  = r_zero;
  assign isInf_op_o   = r_inf;
  assign isSNAN_op_o  = r_snan;
  assign isQNAN_op_o  = r_qnan;

endmodule
`default_nettype wire
